account_store: RTL and testbench
================================

ACCOUNT_STORE -- requirements
Module: account_store

Interface
REQ-001 SHALL have parameter CARD_WIDTH, default 6, card number width.
REQ-002 SHALL have parameter PASS_WIDTH, default 16, PIN width.
REQ-003 SHALL have parameter BLNC_WIDTH, default 20, balance width.
REQ-004 SHALL have parameter USERS_NUMS, default 10, number of accounts; legal range 1..2^CARD_WIDTH.
REQ-005 SHALL have parameter MAX_TRIES, default 3, wrong PINs before lockout; legal range >= 1.
REQ-006 SHALL have parameter PIN_BASE, default 16'h1000, reset PIN seed.
REQ-007 SHALL have parameter INIT_BALANCE, default 1000, reset balance of every account.
REQ-008 SHALL have ports: clk in 1 clock; reset in 1 sync active-high reset; card_in in 1 card inserted strobe; card_no in CARD_WIDTH card number; pin_valid in 1 PIN entry strobe; pin_entry in PASS_WIDTH entered PIN; operation_done in 1 commit strobe; card_out in 1 card eject; update_balance in BLNC_WIDTH new balance; unlock_req in 1 admin unlock strobe; unlock_no in CARD_WIDTH account to unlock; balance out BLNC_WIDTH session balance; auth_ok out 1 session authenticated; card_invalid out 1 unknown card pulse; locked out 1 locked-account pulse; tries_left out $clog2(MAX_TRIES+1) remaining attempts.
REQ-009 SHALL use one clock, clk, with a synchronous active-high reset, reset; all state updates on rising clk edge.

Function
REQ-010 SHALL hold per account i: pin[i] (PASS_WIDTH), bal[i] (BLNC_WIDTH), fail_cnt[i] (0..MAX_TRIES), lock[i] (1 bit).
REQ-011 SHALL implement FSM states IDLE, CHECK, SESSION.
REQ-012 IDLE, card_in=1, card_no>=USERS_NUMS: card_invalid=1 for exactly the next cycle; stay IDLE.
REQ-013 IDLE, card_in=1, valid card_no, lock[card_no]=1: locked=1 for exactly the next cycle; stay IDLE.
REQ-014 IDLE, card_in=1, valid and unlocked: latch card_no into cur; go CHECK next cycle.
REQ-015 CHECK, pin_valid=1, pin_entry==pin[cur]: fail_cnt[cur]<=0; go SESSION; auth_ok=1 from the next cycle.
REQ-016 CHECK, pin_valid=1, mismatch: fail_cnt[cur] incremented; if the new value equals MAX_TRIES, set lock[cur], pulse locked for one cycle, return IDLE; else stay CHECK.
REQ-017 CHECK, card_out=1: return IDLE, no database change; card_out takes priority over a simultaneous pin_valid.
REQ-018 SESSION, operation_done=1, card_out=0: bal[cur]<=update_balance; stay SESSION; balance reflects new value the following cycle.
REQ-019 SESSION, operation_done=1 and card_out=1 same cycle: bal[cur]<=update_balance, then return IDLE.
REQ-020 SESSION, card_out=1 alone: return IDLE, no write.
REQ-021 balance SHALL equal bal[cur] registered while in SESSION, 0 in any other state; auth_ok=1 only in SESSION.
REQ-022 tries_left SHALL equal MAX_TRIES-fail_cnt[cur] in CHECK and SESSION, MAX_TRIES in IDLE.
REQ-023 card_in SHALL be ignored outside IDLE; pin_valid outside CHECK; operation_done outside SESSION.
REQ-024 unlock_req=1 with unlock_no<USERS_NUMS SHALL clear lock and fail_cnt of that account in any state; out-of-range unlock_no ignored.
REQ-025 unlock_req for account cur in the same cycle as a lockout-causing mismatch: unlock wins, lock stays 0, fail_cnt=0, FSM stays CHECK.
REQ-026 update_balance SHALL be written unmodified (no saturation, no arithmetic).

Reset
REQ-027 On reset: state IDLE; cur=0; balance=0; auth_ok=0; card_invalid=0; locked=0; tries_left=MAX_TRIES.
REQ-028 On reset: pin[i]=PIN_BASE+i modulo 2^PASS_WIDTH; bal[i]=INIT_BALANCE; fail_cnt[i]=0; lock[i]=0, for all i.
REQ-029 Reset asserted mid-session SHALL abandon the session and reinitialise the whole database; no pending commit survives.

Verification (defaults)
REQ-030 card_in, card_no=3; pin_entry=16'h1003 -> auth_ok=1, balance=1000, tries_left=3.
REQ-031 In session card 3, operation_done with update_balance=750, then card_out; reinsert card 3, PIN 16'h1003 -> balance=750.
REQ-032 card_no=12 -> card_invalid high one cycle, FSM stays IDLE, auth_ok=0.
REQ-033 card 5, three wrong PINs -> tries_left 3,2,1, then locked pulse and IDLE; reinsert card 5 -> locked pulse, no CHECK.
REQ-034 After REQ-033, unlock_req with unlock_no=5, then card 5 PIN 16'h1005 -> auth_ok=1, tries_left=3.
REQ-035 Card 2 session, operation_done and card_out same cycle, update_balance=0 -> bal[2]=0 on re-authentication; reset mid-session -> bal[2]=1000.

Source files
------------

// File: rtl/account_store.sv
// Account database and card/PIN session controller.
// Holds per-account PIN, balance, wrong-PIN count and lock flag, and sequences one card session at a time.
module account_store #(
    parameter int CARD_WIDTH   = 6,
    parameter int PASS_WIDTH   = 16,
    parameter int BLNC_WIDTH   = 20,
    parameter int USERS_NUMS   = 10,
    parameter int MAX_TRIES    = 3,
    parameter int PIN_BASE     = 16'h1000,
    parameter int INIT_BALANCE = 1000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             card_in,
    input  logic [CARD_WIDTH-1:0]            card_no,
    input  logic                             pin_valid,
    input  logic [PASS_WIDTH-1:0]            pin_entry,
    input  logic                             operation_done,
    input  logic                             card_out,
    input  logic [BLNC_WIDTH-1:0]            update_balance,
    input  logic                             unlock_req,
    input  logic [CARD_WIDTH-1:0]            unlock_no,
    output logic [BLNC_WIDTH-1:0]            balance,
    output logic                             auth_ok,
    output logic                             card_invalid,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int IW = (USERS_NUMS > 1) ? $clog2(USERS_NUMS) : 1;
    localparam logic [TW-1:0]         MAX_T   = TW'(MAX_TRIES);
    localparam logic [CARD_WIDTH:0]   USERS_W = USERS_NUMS[CARD_WIDTH:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        SESSION = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          cur_q, cur_d;
    logic                   card_invalid_q, card_invalid_d;
    logic                   locked_q, locked_d;
    logic [PASS_WIDTH-1:0]  pin_q  [USERS_NUMS];
    logic [BLNC_WIDTH-1:0]  bal_q  [USERS_NUMS];
    logic [BLNC_WIDTH-1:0]  bal_d  [USERS_NUMS];
    logic [TW-1:0]          fail_q [USERS_NUMS];
    logic [TW-1:0]          fail_d [USERS_NUMS];
    logic                   lock_q [USERS_NUMS];
    logic                   lock_d [USERS_NUMS];

    logic                   card_ok, unlock_ok, lockout;
    logic [IW-1:0]          card_idx, unlock_idx;
    logic [TW-1:0]          fail_next;

    // Indices are only used after the range check has qualified them.
    assign card_ok    = {1'b0, card_no}   < USERS_W;
    assign unlock_ok  = {1'b0, unlock_no} < USERS_W;
    assign card_idx   = card_no[IW-1:0];
    assign unlock_idx = unlock_no[IW-1:0];
    assign fail_next  = fail_q[cur_q] + TW'(1);

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        bal_d          = bal_q;
        fail_d         = fail_q;
        lock_d         = lock_q;
        card_invalid_d = 1'b0;
        locked_d       = 1'b0;
        lockout        = 1'b0;

        case (state_q)
            IDLE: begin
                if (card_in) begin
                    if (!card_ok) begin
                        card_invalid_d = 1'b1;
                    end else if (lock_q[card_idx]) begin
                        locked_d = 1'b1;
                    end else begin
                        cur_d   = card_idx;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (card_out) begin
                    state_d = IDLE;
                end else if (pin_valid) begin
                    if (pin_entry == pin_q[cur_q]) begin
                        fail_d[cur_q] = '0;
                        state_d       = SESSION;
                    end else begin
                        fail_d[cur_q] = fail_next;
                        if (fail_next == MAX_T) begin
                            lockout       = 1'b1;
                            lock_d[cur_q] = 1'b1;
                            locked_d      = 1'b1;
                            state_d       = IDLE;
                        end
                    end
                end
            end
            SESSION: begin
                if (operation_done) begin
                    bal_d[cur_q] = update_balance;
                end
                if (card_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Admin unlock overrides anything the FSM did to the same account this cycle.
        if (unlock_req && unlock_ok) begin
            lock_d[unlock_idx] = 1'b0;
            fail_d[unlock_idx] = '0;
            if (lockout && (unlock_idx == cur_q)) begin
                locked_d = 1'b0;
                state_d  = CHECK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            card_invalid_q <= 1'b0;
            locked_q       <= 1'b0;
            for (int i = 0; i < USERS_NUMS; i++) begin
                pin_q[i]  <= PASS_WIDTH'(PIN_BASE + i);
                bal_q[i]  <= BLNC_WIDTH'(INIT_BALANCE);
                fail_q[i] <= '0;
                lock_q[i] <= 1'b0;
            end
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            card_invalid_q <= card_invalid_d;
            locked_q       <= locked_d;
            bal_q          <= bal_d;
            fail_q         <= fail_d;
            lock_q         <= lock_d;
        end
    end

    assign auth_ok      = (state_q == SESSION);
    assign balance      = auth_ok ? bal_q[cur_q] : '0;
    assign tries_left   = (state_q == IDLE) ? MAX_T : (MAX_T - fail_q[cur_q]);
    assign card_invalid = card_invalid_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_account_store.sv
// Directed self-checking bench for account_store at default parameters.
module tb_account_store;

    logic        clk;
    logic        reset;
    logic        card_in;
    logic [5:0]  card_no;
    logic        pin_valid;
    logic [15:0] pin_entry;
    logic        operation_done;
    logic        card_out;
    logic [19:0] update_balance;
    logic        unlock_req;
    logic [5:0]  unlock_no;
    logic [19:0] balance;
    logic        auth_ok;
    logic        card_invalid;
    logic        locked;
    logic [1:0]  tries_left;

    int checks = 0;
    int errors = 0;

    account_store dut (
        .clk            (clk),
        .reset          (reset),
        .card_in        (card_in),
        .card_no        (card_no),
        .pin_valid      (pin_valid),
        .pin_entry      (pin_entry),
        .operation_done (operation_done),
        .card_out       (card_out),
        .update_balance (update_balance),
        .unlock_req     (unlock_req),
        .unlock_no      (unlock_no),
        .balance        (balance),
        .auth_ok        (auth_ok),
        .card_invalid   (card_invalid),
        .locked         (locked),
        .tries_left     (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns later, then drop all strobes.
    task automatic cycle();
        @(posedge clk);
        #1;
        card_in        = 1'b0;
        pin_valid      = 1'b0;
        operation_done = 1'b0;
        card_out       = 1'b0;
        unlock_req     = 1'b0;
    endtask

    task automatic insert(input logic [5:0] n);
        card_no = n;
        card_in = 1'b1;
        cycle();
    endtask

    task automatic enter_pin(input logic [15:0] p);
        pin_entry = p;
        pin_valid = 1'b1;
        cycle();
    endtask

    task automatic eject();
        card_out = 1'b1;
        cycle();
    endtask

    initial begin
        reset = 1'b1; card_in = 0; card_no = 0; pin_valid = 0; pin_entry = 0;
        operation_done = 0; card_out = 0; update_balance = 0; unlock_req = 0; unlock_no = 0;
        cycle(); cycle();
        reset = 1'b0;
        chk("rst_balance", 32'(balance), 0);
        chk("rst_auth", 32'(auth_ok), 0);
        chk("rst_inval", 32'(card_invalid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_tries", 32'(tries_left), 3);

        // Card 3 login
        insert(3);
        chk("c3_check_auth", 32'(auth_ok), 0);
        chk("c3_check_tries", 32'(tries_left), 3);
        enter_pin(16'h1003);
        chk("c3_auth", 32'(auth_ok), 1);
        chk("c3_bal", 32'(balance), 1000);
        chk("c3_tries", 32'(tries_left), 3);

        // Commit 750, eject, re-login
        update_balance = 20'd750; operation_done = 1'b1; cycle();
        chk("c3_commit_bal", 32'(balance), 750);
        chk("c3_commit_auth", 32'(auth_ok), 1);
        eject();
        chk("c3_eject_auth", 32'(auth_ok), 0);
        chk("c3_eject_bal", 32'(balance), 0);
        insert(3); enter_pin(16'h1003);
        chk("c3_relogin_bal", 32'(balance), 750);
        update_balance = 20'hFFFFF; operation_done = 1'b1; cycle();
        chk("c3_full_bal", 32'(balance), 32'hFFFFF);
        eject();

        // Invalid cards
        insert(12);
        chk("c12_inval", 32'(card_invalid), 1);
        chk("c12_auth", 32'(auth_ok), 0);
        chk("c12_tries", 32'(tries_left), 3);
        cycle();
        chk("c12_inval_drop", 32'(card_invalid), 0);
        enter_pin(16'h100C);
        chk("c12_pin_ignored", 32'(auth_ok), 0);
        insert(10);
        chk("c10_inval", 32'(card_invalid), 1);
        insert(9);
        chk("c9_valid", 32'(card_invalid), 0);
        enter_pin(16'h1009);
        chk("c9_auth", 32'(auth_ok), 1);
        eject();

        // Card 5 lockout
        insert(5);
        chk("c5_tries3", 32'(tries_left), 3);
        enter_pin(16'h0000);
        chk("c5_tries2", 32'(tries_left), 2);
        chk("c5_nolock1", 32'(locked), 0);
        enter_pin(16'h0000);
        chk("c5_tries1", 32'(tries_left), 1);
        enter_pin(16'h0000);
        chk("c5_locked", 32'(locked), 1);
        chk("c5_lock_tries", 32'(tries_left), 3);
        chk("c5_lock_auth", 32'(auth_ok), 0);
        cycle();
        chk("c5_locked_drop", 32'(locked), 0);
        insert(5);
        chk("c5_reinsert_locked", 32'(locked), 1);
        enter_pin(16'h1005);
        chk("c5_no_check", 32'(auth_ok), 0);

        // Unlock card 5
        unlock_no = 6'd5; unlock_req = 1'b1; cycle();
        insert(5);
        chk("c5_unlocked_nolock", 32'(locked), 0);
        enter_pin(16'h1005);
        chk("c5_unlock_auth", 32'(auth_ok), 1);
        chk("c5_unlock_tries", 32'(tries_left), 3);
        eject();

        // Unlock racing a lockout on card 7
        insert(7); enter_pin(16'h0001); enter_pin(16'h0001);
        chk("c7_tries1", 32'(tries_left), 1);
        pin_entry = 16'h0001; pin_valid = 1'b1; unlock_no = 6'd7; unlock_req = 1'b1; cycle();
        chk("c7_race_locked", 32'(locked), 0);
        chk("c7_race_tries", 32'(tries_left), 3);
        enter_pin(16'h1007);
        chk("c7_race_auth", 32'(auth_ok), 1);
        eject();

        // card_out beats pin_valid in CHECK
        insert(4);
        pin_entry = 16'h1004; pin_valid = 1'b1; card_out = 1'b1; cycle();
        chk("c4_prio_auth", 32'(auth_ok), 0);
        insert(4);
        pin_entry = 16'h0000; pin_valid = 1'b1; card_out = 1'b1; cycle();
        insert(4);
        chk("c4_prio_nofail", 32'(tries_left), 3);
        enter_pin(16'h1004);
        chk("c4_auth", 32'(auth_ok), 1);
        eject();

        // Card 2: commit with eject, then reset mid-session
        insert(2); enter_pin(16'h1002);
        chk("c2_bal_init", 32'(balance), 1000);
        update_balance = 20'd0; operation_done = 1'b1; card_out = 1'b1; cycle();
        chk("c2_exit_auth", 32'(auth_ok), 0);
        insert(2); enter_pin(16'h1002);
        chk("c2_bal_zero", 32'(balance), 0);
        chk("c2_auth", 32'(auth_ok), 1);
        update_balance = 20'd123; operation_done = 1'b1; reset = 1'b1; cycle();
        reset = 1'b0;
        chk("c2_rst_auth", 32'(auth_ok), 0);
        chk("c2_rst_bal", 32'(balance), 0);
        chk("c2_rst_tries", 32'(tries_left), 3);
        insert(2); enter_pin(16'h1002);
        chk("c2_after_rst_bal", 32'(balance), 1000);
        eject();
        insert(3); enter_pin(16'h1003);
        chk("c3_after_rst_bal", 32'(balance), 1000);
        eject();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
